wb_deserializer: RTL and testbench

WB_DESERIALIZER -- requirements
Module: wb_deserializer

---
 rtl/wb_deserializer_pkg.sv | 18 +
 rtl/wb_deserializer_if.sv | 23 ++
 rtl/wb_deserializer_core.sv | 73 +++++++
 rtl/wb_deserializer.sv | 90 +++++++++
 tb/tb_wb_deserializer.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/wb_deserializer_pkg.sv
// rtl/wb_deserializer_pkg.sv - shared constants, register map and FSM states for the Wishbone deserializer
package WBDeserializer;

    localparam int SYM_BITS   = 9;
    localparam int FRAME_BITS = 3 * SYM_BITS;

    localparam logic [1:0] NUM_REGS  = 2'd2;
    localparam int         ADDR_SIZE = $bits(NUM_REGS);

    localparam int ADR_DATA   = 0;
    localparam int ADR_STATUS = 1;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } core_state_t;

endpackage

// File: rtl/wb_deserializer_if.sv
// rtl/wb_deserializer_if.sv - Wishbone classic slave bus bundle
interface wb_deserializer_if;

    logic        CYC_I;
    logic        STB_I;
    logic        WE_I;
    logic [31:0] ADR_I;
    logic [31:0] DAT_I;
    logic        ACK_O;
    logic        ERR_O;
    logic [31:0] DAT_O;

    modport slave (
        input  CYC_I, STB_I, WE_I, ADR_I, DAT_I,
        output ACK_O, ERR_O, DAT_O
    );

    modport master (
        output CYC_I, STB_I, WE_I, ADR_I, DAT_I,
        input  ACK_O, ERR_O, DAT_O
    );

endinterface

// File: rtl/wb_deserializer_core.sv
// rtl/wb_deserializer_core.sv - serial-to-parallel frame assembler with bit counter
module deserializer_core #(
    parameter int FRAME_BITS = WBDeserializer::FRAME_BITS
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  data_i,
    input  logic                  ena_i,
    output logic [FRAME_BITS-1:0] frame_o,
    output logic                  done_o,
    output logic                  abort_o
);
    import WBDeserializer::*;

    localparam logic [4:0] LAST_CNT = 5'(FRAME_BITS - 1);

    core_state_t           state_q, state_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] sreg_q, sreg_d;
    logic [FRAME_BITS-1:0] shifted;

    // The completed frame includes the bit arriving on this cycle, so the
    // wrapper can capture it on the same edge as the last bit.
    assign shifted = {sreg_q[FRAME_BITS-2:0], data_i};
    assign frame_o = shifted;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        done_o  = 1'b0;
        abort_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ena_i) begin
                    sreg_d  = shifted;
                    cnt_d   = 5'd1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (ena_i) begin
                    sreg_d = shifted;
                    if (cnt_q == LAST_CNT) begin
                        done_o  = 1'b1;
                        cnt_d   = 5'd0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end else begin
                    abort_o = 1'b1;
                    cnt_d   = 5'd0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
        end
    end

endmodule

// File: rtl/wb_deserializer.sv
// rtl/wb_deserializer.sv - serial frame receiver with Wishbone register file and frame-ready irq
module wb_deserializer #(
    parameter int SYM_BITS   = WBDeserializer::SYM_BITS,
    parameter int FRAME_BITS = 3 * SYM_BITS
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               data_i,
    input  logic               ena_i,
    wb_deserializer_if.slave   bus,
    output logic               irq_o
);
    import WBDeserializer::*;

    logic [FRAME_BITS-1:0] frame;
    logic                  done;
    logic                  abort_p;

    logic [FRAME_BITS-1:0] rx_data;
    logic                  valid, ovf, abort_err;
    logic                  ack_q, err_q;
    logic [31:0]           dat_q;

    logic [ADDR_SIZE-1:0]  adr;
    logic                  req, hit_data_rd, hit_status, acc_ok, acc_bad;
    logic                  rd_data, rd_status, wr_status;
    logic                  unused_bits;

    deserializer_core #(
        .FRAME_BITS (FRAME_BITS)
    ) u_core (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .ena_i   (ena_i),
        .frame_o (frame),
        .done_o  (done),
        .abort_o (abort_p)
    );

    // Blocking new requests while a response is out forces the idle cycle
    // between acknowledges and keeps read side effects to one per access.
    assign req         = bus.CYC_I & bus.STB_I & ~ack_q & ~err_q;
    assign adr         = bus.ADR_I[ADDR_SIZE-1:0];
    assign hit_data_rd = ~bus.WE_I & (adr == ADDR_SIZE'(ADR_DATA));
    assign hit_status  = (adr == ADDR_SIZE'(ADR_STATUS));
    assign acc_ok      = req & (hit_data_rd | hit_status);
    assign acc_bad     = req & ~(hit_data_rd | hit_status);
    assign rd_data     = acc_ok & hit_data_rd;
    assign rd_status   = acc_ok & hit_status & ~bus.WE_I;
    assign wr_status   = acc_ok & hit_status & bus.WE_I;
    assign unused_bits = ^{bus.ADR_I[31:ADDR_SIZE], bus.DAT_I[31:3], bus.DAT_I[0]};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rx_data   <= '0;
            valid     <= 1'b0;
            ovf       <= 1'b0;
            abort_err <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= 32'd0;
        end else begin
            ack_q <= acc_ok;
            err_q <= acc_bad;
            if (rd_data)        dat_q <= 32'(rx_data);
            else if (rd_status) dat_q <= 32'({ovf, abort_err, valid});
            else                dat_q <= 32'd0;

            if (done) rx_data <= frame;

            // A frame landing on the same edge as a data read replaces the
            // frame being read, so it is neither lost nor an overflow.
            if (done)         valid <= 1'b1;
            else if (rd_data) valid <= 1'b0;

            if (done && valid && !rd_data)     ovf <= 1'b1;
            else if (wr_status && bus.DAT_I[2]) ovf <= 1'b0;

            if (abort_p)                        abort_err <= 1'b1;
            else if (wr_status && bus.DAT_I[1]) abort_err <= 1'b0;
        end
    end

    assign bus.ACK_O = ack_q;
    assign bus.ERR_O = err_q;
    assign bus.DAT_O = dat_q;
    assign irq_o     = valid;

endmodule

// File: tb/tb_wb_deserializer.sv
// tb/tb_wb_deserializer.sv - scoreboard bench for wb_deserializer frames, status and bus errors
module tb_wb_deserializer;
    import WBDeserializer::*;

    logic clk_i  = 1'b0;
    logic rst_i  = 1'b0;
    logic data_i = 1'b0;
    logic ena_i  = 1'b0;
    logic irq_o;

    wb_deserializer_if bus();

    wb_deserializer dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .data_i (data_i),
        .ena_i  (ena_i),
        .bus    (bus),
        .irq_o  (irq_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // {expect_err, expected DAT_O}
    logic [32:0] sb_q[$];

    logic [26:0] m_rx;
    logic        m_valid, m_ovf, m_abort;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_frame(input logic [26:0] f, input bit read_same_edge);
        if (m_valid && !read_same_edge) m_ovf = 1'b1;
        m_rx    = f;
        m_valid = 1'b1;
    endfunction

    task automatic send_bits(input logic [26:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            data_i = f[26-i];
            ena_i  = 1'b1;
            @(posedge clk_i); #1;
        end
    endtask

    task automatic send_frame(input logic [26:0] f);
        send_bits(f, 27);
        ena_i  = 1'b0;
        data_i = 1'b0;
        model_frame(f, 1'b0);
        @(posedge clk_i); #1;
    endtask

    task automatic wb_start(input logic [31:0] addr, input logic we, input logic [31:0] dat);
        logic [1:0] a;
        a = addr[1:0];
        if (a == 2'(ADR_DATA) && !we) begin
            sb_q.push_back({1'b0, 32'(m_rx)});
            m_valid = 1'b0;
        end else if (a == 2'(ADR_STATUS) && !we) begin
            sb_q.push_back({1'b0, 29'd0, m_ovf, m_abort, m_valid});
        end else if (a == 2'(ADR_STATUS)) begin
            sb_q.push_back({1'b0, 32'd0});
            if (dat[2]) m_ovf   = 1'b0;
            if (dat[1]) m_abort = 1'b0;
        end else begin
            sb_q.push_back({1'b1, 32'd0});
        end
        bus.CYC_I = 1'b1;
        bus.STB_I = 1'b1;
        bus.WE_I  = we;
        bus.ADR_I = addr;
        bus.DAT_I = dat;
    endtask

    task automatic wb_finish(input string tag);
        int          n;
        logic [32:0] e;
        n = 0;
        do begin
            @(posedge clk_i); #1;
            ena_i = 1'b0;  // releases a serial bit overlapped with the request
            n++;
        end while (!(bus.ACK_O || bus.ERR_O) && n < 8);
        e = sb_q.pop_front();
        chk({tag, " latency"}, 32'(n), 32'd1);
        chk({tag, " ack"}, 32'(bus.ACK_O), 32'(!e[32]));
        chk({tag, " err"}, 32'(bus.ERR_O), 32'(e[32]));
        chk({tag, " dat"}, bus.DAT_O, e[31:0]);
        bus.CYC_I = 1'b0;
        bus.STB_I = 1'b0;
        bus.WE_I  = 1'b0;
        @(posedge clk_i); #1;
        chk({tag, " pulse"}, 32'({bus.ACK_O, bus.ERR_O}), 32'd0);
        chk({tag, " dat idle"}, bus.DAT_O, 32'd0);
        chk({tag, " irq"}, 32'(irq_o), 32'(m_valid));
    endtask

    task automatic wb_read(input logic [31:0] addr, input string tag);
        wb_start(addr, 1'b0, 32'd0);
        wb_finish(tag);
    endtask

    task automatic wb_write(input logic [31:0] addr, input logic [31:0] dat, input string tag);
        wb_start(addr, 1'b1, dat);
        wb_finish(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [26:0] f1, fa, fb;
        bus.CYC_I = 1'b0;
        bus.STB_I = 1'b0;
        bus.WE_I  = 1'b0;
        bus.ADR_I = 32'd0;
        bus.DAT_I = 32'd0;
        m_rx = '0; m_valid = 1'b0; m_ovf = 1'b0; m_abort = 1'b0;

        repeat (3) @(posedge clk_i);
        #1;
        chk("reset ack", 32'(bus.ACK_O), 32'd0);
        chk("reset err", 32'(bus.ERR_O), 32'd0);
        chk("reset dat", bus.DAT_O, 32'd0);
        chk("reset irq", 32'(irq_o), 32'd0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        wb_read(32'(ADR_STATUS), "reset status");

        // kcode BC followed by data AA, 55
        f1 = {9'h1BC, 9'h0AA, 9'h055};
        send_frame(f1);
        chk("f1 irq", 32'(irq_o), 32'd1);
        wb_read(32'(ADR_STATUS), "f1 status");
        wb_read(32'(ADR_DATA), "f1 data");
        wb_read(32'(ADR_STATUS), "f1 status after read");

        send_bits(27'(($urandom)), 10);
        ena_i = 1'b0;
        m_abort = 1'b1;
        @(posedge clk_i); #1;
        wb_read(32'(ADR_STATUS), "abort status");
        wb_write(32'(ADR_STATUS), 32'h2, "abort clear");
        wb_read(32'(ADR_STATUS), "abort status cleared");

        fa = 27'($urandom);
        fb = 27'($urandom);
        send_frame(fa);
        send_frame(fb);
        wb_read(32'(ADR_STATUS), "ovf status");
        wb_read(32'(ADR_DATA), "ovf data");
        wb_write(32'(ADR_STATUS), 32'h2, "ovf keep");
        wb_read(32'(ADR_STATUS), "ovf still set");
        wb_write(32'(ADR_STATUS), 32'h5, "ovf clear");
        wb_read(32'(ADR_STATUS), "ovf cleared");

        fa = 27'($urandom);
        fb = 27'($urandom);
        send_frame(fa);
        send_bits(fb, 26);
        data_i = fb[0];
        ena_i  = 1'b1;
        wb_start(32'(ADR_DATA), 1'b0, 32'd0);
        model_frame(fb, 1'b1);
        wb_finish("coincident read");
        wb_read(32'(ADR_STATUS), "coincident status");
        wb_read(32'(ADR_DATA), "coincident new frame");

        fa = 27'($urandom);
        send_frame(fa);
        wb_read(32'd2, "unmapped read");
        wb_write(32'(ADR_DATA), 32'hFFFF_FFFF, "data write");
        wb_write(32'd3, 32'h6, "unmapped write");
        wb_read(32'(ADR_STATUS), "err status unchanged");
        wb_read(32'(ADR_DATA), "err data unchanged");

        fa = 27'($urandom);
        send_frame(fa);
        send_bits(27'($urandom), 13);
        rst_i = 1'b0;
        ena_i = 1'b0;
        #1;
        chk("async reset irq", 32'(irq_o), 32'd0);
        m_rx = '0; m_valid = 1'b0; m_ovf = 1'b0; m_abort = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        wb_read(32'(ADR_DATA), "post reset data");
        fb = 27'($urandom);
        send_frame(fb);
        wb_read(32'(ADR_STATUS), "post reset status");
        wb_read(32'(ADR_DATA), "post reset frame");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
